// File: rtl/morph_pkg.sv
// Shared selector and border-policy constants for the 3x3 morphology stage.
package morph_pkg;
    localparam logic MODE_ERODE   = 1'b0;
    localparam logic MODE_DILATE  = 1'b1;
    localparam logic SE_CROSS     = 1'b0;
    localparam logic SE_SQUARE    = 1'b1;
    localparam int   BORDER_PASS  = 0;
    localparam int   BORDER_CONST = 1;
endpackage

// File: rtl/morph_cmp3.sv
// Combinational min (erode) or max (dilate) of three unsigned channel values.
module morph_cmp3
    import morph_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic              mode,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W-1:0] ab;

    always_comb begin
        if (mode == MODE_DILATE) begin
            ab = (a > b) ? a : b;
            y  = (ab > c) ? ab : c;
        end else begin
            ab = (a < b) ? a : b;
            y  = (ab < c) ? ab : c;
        end
    end
endmodule

// File: rtl/matrix_morph3x3.sv
// 3x3 per-channel erosion/dilation over a cross or square element with a fixed
// border policy; column/row tracking, flush of the last centre, valid-tagged output.
module matrix_morph3x3
    import morph_pkg::*;
#(
    parameter int PIC_WIDTH   = 250,
    parameter int PIC_HEIGHT  = 250,
    parameter int DATA_W      = 8,
    parameter int CH          = 3,
    parameter int BORDER_MODE = BORDER_PASS,
    parameter int BORDER_VAL  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic [CH*DATA_W-1:0] din1,
    input  logic [CH*DATA_W-1:0] din2,
    input  logic [CH*DATA_W-1:0] din3,
    input  logic                 mode,
    input  logic                 se_sel,
    output logic [CH*DATA_W-1:0] dout,
    output logic                 valid_out
);
    localparam int WIDTH = CH * DATA_W;
    localparam int CW    = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
    localparam int RW    = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [CW-1:0]     COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(PIC_HEIGHT - 1);
    localparam logic [DATA_W-1:0] BVAL     = DATA_W'(BORDER_VAL);

    // Tap index 0 is the newest (right) column, 2 the oldest (left).
    logic [WIDTH-1:0]  top_p0 [3];
    logic [WIDTH-1:0]  mid_p0 [3];
    logic [WIDTH-1:0]  bot_p0 [3];
    logic [WIDTH-1:0]  last_ctr_p0;
    logic [CW-1:0]     col_p0;
    logic [RW-1:0]     row_p0;
    logic              vld_p0, bord_p0, flush_arm_p0, flush_p0;

    logic [DATA_W-1:0] colsel_d  [CH][3];
    logic [DATA_W-1:0] colred_p1 [CH][3];
    logic [WIDTH-1:0]  ctr_p1;
    logic              bord_p1, mode_p1, vld_p1;
    logic [DATA_W-1:0] red_d [CH];
    logic [WIDTH-1:0]  res_d;

    // ---- stage 0: taps, position counters, window/flush tagging ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                top_p0[k] <= '0;
                mid_p0[k] <= '0;
                bot_p0[k] <= '0;
            end
            last_ctr_p0  <= '0;
            col_p0       <= '0;
            row_p0       <= '0;
            vld_p0       <= 1'b0;
            bord_p0      <= 1'b0;
            flush_arm_p0 <= 1'b0;
            flush_p0     <= 1'b0;
        end else begin
            // Beat at col c completes the window centred at c-1; col 0 completes none.
            vld_p0       <= valid_in && (col_p0 != '0);
            bord_p0      <= (col_p0 == CW'(1)) || (row_p0 == '0) || (row_p0 == ROW_LAST);
            // Flush is held back one extra cycle so it trails the centre W-2 window.
            flush_arm_p0 <= valid_in && (col_p0 == COL_LAST);
            flush_p0     <= flush_arm_p0;
            if (valid_in) begin
                top_p0[0] <= din1;
                mid_p0[0] <= din2;
                bot_p0[0] <= din3;
                for (int k = 1; k < 3; k++) begin
                    top_p0[k] <= top_p0[k-1];
                    mid_p0[k] <= mid_p0[k-1];
                    bot_p0[k] <= bot_p0[k-1];
                end
                if (col_p0 == COL_LAST) begin
                    col_p0      <= '0;
                    last_ctr_p0 <= din2;
                    row_p0      <= (row_p0 == ROW_LAST) ? '0 : row_p0 + RW'(1);
                end else begin
                    col_p0 <= col_p0 + CW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        for (genvar k = 0; k < 3; k++) begin : g_col
            logic [DATA_W-1:0] vert;
            morph_cmp3 #(.DATA_W(DATA_W)) u_vert (
                .a    (top_p0[k][g*DATA_W +: DATA_W]),
                .b    (mid_p0[k][g*DATA_W +: DATA_W]),
                .c    (bot_p0[k][g*DATA_W +: DATA_W]),
                .mode (mode),
                .y    (vert)
            );
            // A cross keeps only the centre row in the left and right columns.
            assign colsel_d[g][k] = ((k == 1) || (se_sel == SE_SQUARE)) ?
                                    vert : mid_p0[k][g*DATA_W +: DATA_W];
        end
        morph_cmp3 #(.DATA_W(DATA_W)) u_final (
            .a    (colred_p1[g][0]),
            .b    (colred_p1[g][1]),
            .c    (colred_p1[g][2]),
            .mode (mode_p1),
            .y    (red_d[g])
        );
    end

    // ---- stage 1: column reductions, centre, border flag, mode ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < CH; g++)
                for (int k = 0; k < 3; k++)
                    colred_p1[g][k] <= '0;
            ctr_p1  <= '0;
            bord_p1 <= 1'b0;
            mode_p1 <= MODE_ERODE;
            vld_p1  <= 1'b0;
        end else begin
            for (int g = 0; g < CH; g++)
                for (int k = 0; k < 3; k++)
                    colred_p1[g][k] <= colsel_d[g][k];
            ctr_p1  <= vld_p0 ? mid_p0[1] : last_ctr_p0;
            bord_p1 <= vld_p0 ? bord_p0 : 1'b1;
            mode_p1 <= mode;
            vld_p1  <= vld_p0 | flush_p0;
        end
    end

    always_comb begin
        res_d = '0;
        for (int g = 0; g < CH; g++) begin
            if (!bord_p1)
                res_d[g*DATA_W +: DATA_W] = red_d[g];
            else if (BORDER_MODE == BORDER_CONST)
                res_d[g*DATA_W +: DATA_W] = BVAL;
            else
                res_d[g*DATA_W +: DATA_W] = ctr_p1[g*DATA_W +: DATA_W];
        end
    end

    // ---- stage 2: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            valid_out <= 1'b0;
        end else begin
            dout      <= res_d;
            valid_out <= vld_p1;
        end
    end
endmodule

// File: tb/tb_matrix_morph3x3.sv
// Randomised self-checking bench for matrix_morph3x3 (4x4 frames, 3x8-bit channels).
`timescale 1ns/1ps
module tb_matrix_morph3x3;
    import morph_pkg::*;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, mode = 1'b0, se_sel = 1'b0;
    logic [23:0] din1 = '0, din2 = '0, din3 = '0;
    logic [23:0] dout_a, dout_b;
    logic        vo_a, vo_b;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, first_vo_cyc = -1, beat1_edge = -1;
    logic [23:0] frame [H][W];
    logic [23:0] q_a[$], q_b[$], saved[$];
    logic [23:0] exp_v;

    matrix_morph3x3 #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .DATA_W(8), .CH(3),
                      .BORDER_MODE(BORDER_PASS), .BORDER_VAL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .din1(din1), .din2(din2), .din3(din3),
        .mode(mode), .se_sel(se_sel), .dout(dout_a), .valid_out(vo_a));

    matrix_morph3x3 #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .DATA_W(8), .CH(3),
                      .BORDER_MODE(BORDER_CONST), .BORDER_VAL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .din1(din1), .din2(din2), .din3(din3),
        .mode(mode), .se_sel(se_sel), .dout(dout_b), .valid_out(vo_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vo_a) begin
            if (q_a.size() == 0) first_vo_cyc = cyc;
            q_a.push_back(dout_a);
        end
        if (vo_b) q_b.push_back(dout_b);
    end

    // Reference: per-channel min/max over the chosen neighbourhood, border by policy.
    function automatic logic [23:0] model_px(int r, int c, logic md, logic se, int bmode);
        logic [23:0] res;
        int best, v;
        res = '0;
        if (r == 0 || r == H-1 || c == 0 || c == W-1)
            return (bmode == BORDER_CONST) ? 24'h0 : frame[r][c];
        for (int ch = 0; ch < 3; ch++) begin
            best = int'(frame[r][c][ch*8 +: 8]);
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (se || dr == 0 || dc == 0) begin
                        v = int'(frame[r+dr][c+dc][ch*8 +: 8]);
                        if (md) best = (v > best) ? v : best;
                        else    best = (v < best) ? v : best;
                    end
            res[ch*8 +: 8] = best[7:0];
        end
        return res;
    endfunction

    task automatic fill_frame(input logic [23:0] val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = val;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = 24'($urandom);
    endtask

    task automatic run_frame(input int gap_pct);
        int ng;
        q_a.delete();
        q_b.delete();
        first_vo_cyc = -1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                ng = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
                repeat (ng) begin
                    @(negedge clk);
                    valid_in = 1'b0;
                    din1 = 24'($urandom); din2 = 24'($urandom); din3 = 24'($urandom);
                end
                @(negedge clk);
                valid_in = 1'b1;
                din1 = (r > 0)   ? frame[r-1][c] : 24'($urandom);
                din2 = frame[r][c];
                din3 = (r < H-1) ? frame[r+1][c] : 24'($urandom);
                if (r == 0 && c == 1) beat1_edge = cyc + 1;
            end
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 40 && q_a.size() < W*H; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (vo_a !== 1'b0 || vo_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b required 0/0", vo_a, vo_b);
        end
        n_checks++;
        if (dout_a !== 24'h0 || dout_b !== 24'h0) begin
            n_fail++; $display("FAIL reset_dout: got %06h/%06h required 0", dout_a, dout_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (vo_a !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b required 0", vo_a); end
    endtask

    task automatic test_flat_erode_cross();
        fill_frame(24'h101010);
        mode = MODE_ERODE; se_sel = SE_CROSS;
        run_frame(0);
        n_checks++;
        if (q_a.size() !== W*H) begin
            n_fail++; $display("FAIL flat_count: got %0d required %0d", q_a.size(), W*H);
        end
        foreach (q_a[i]) begin
            n_checks++;
            if (q_a[i] !== 24'h101010) begin
                n_fail++; $display("FAIL flat_px[%0d]: got %06h required 101010", i, q_a[i]);
            end
        end
        n_checks++;
        if (first_vo_cyc !== beat1_edge + 2) begin
            n_fail++; $display("FAIL flat_latency: first output at edge %0d required %0d", first_vo_cyc, beat1_edge + 2);
        end
    endtask

    task automatic test_dilate_square();
        fill_frame(24'h202020);
        frame[1][1] = 24'hFFFFFF;
        mode = MODE_DILATE; se_sel = SE_SQUARE;
        run_frame(0);
        n_checks++;
        if (q_a.size() !== W*H) begin
            n_fail++; $display("FAIL dil_count: got %0d required %0d", q_a.size(), W*H);
        end
        foreach (q_a[i]) if (i < W*H) begin
            exp_v = model_px(i / W, i % W, mode, se_sel, BORDER_PASS);
            n_checks++;
            if (q_a[i] !== exp_v) begin
                n_fail++; $display("FAIL dil_px[%0d]: got %06h required %06h", i, q_a[i], exp_v);
            end
        end
        n_checks++;
        if (q_a.size() > 10 && q_a[10] !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL dil_r2c2: got %06h required ffffff", q_a[10]);
        end
    endtask

    task automatic test_erode_corner();
        fill_frame(24'h808080);
        frame[0][0] = 24'h000000;
        mode = MODE_ERODE; se_sel = SE_CROSS;
        run_frame(0);
        n_checks++;
        if (q_a.size() < 6 || q_a[5] !== 24'h808080) begin
            n_fail++; $display("FAIL corner_cross: got %06h required 808080", (q_a.size() > 5) ? q_a[5] : 24'hx);
        end
        se_sel = SE_SQUARE;
        run_frame(0);
        n_checks++;
        if (q_a.size() < 6 || q_a[5] !== 24'h000000) begin
            n_fail++; $display("FAIL corner_square: got %06h required 000000", (q_a.size() > 5) ? q_a[5] : 24'hx);
        end
        n_checks++;
        if (q_a.size() > 0 && q_a[0] !== 24'h000000) begin
            n_fail++; $display("FAIL corner_border: got %06h required 000000", q_a[0]);
        end
    endtask

    task automatic test_channel_isolation();
        fill_frame(24'h407777);
        frame[2][2] = 24'h057777;
        mode = MODE_ERODE; se_sel = SE_CROSS;
        run_frame(0);
        n_checks++;
        if (q_a.size() !== W*H) begin
            n_fail++; $display("FAIL chan_count: got %0d required %0d", q_a.size(), W*H);
        end
        foreach (q_a[i]) if (i < W*H) begin
            exp_v = (i == 6 || i == 9 || i == 10) ? 24'h057777 : 24'h407777;
            n_checks++;
            if (q_a[i] !== exp_v) begin
                n_fail++; $display("FAIL chan_px[%0d]: got %06h required %06h", i, q_a[i], exp_v);
            end
        end
    endtask

    task automatic test_gaps_and_reset();
        fill_random();
        mode = 1'($urandom); se_sel = 1'($urandom);
        run_frame(0);
        saved = q_a;
        run_frame(45);
        n_checks++;
        if (q_a.size() !== saved.size()) begin
            n_fail++; $display("FAIL gap_count: got %0d required %0d", q_a.size(), saved.size());
        end
        foreach (q_a[i]) if (i < W*H) begin
            exp_v = model_px(i / W, i % W, mode, se_sel, BORDER_PASS);
            n_checks++;
            if (q_a[i] !== exp_v || (i < saved.size() && q_a[i] !== saved[i])) begin
                n_fail++; $display("FAIL gap_px[%0d]: got %06h required %06h", i, q_a[i], exp_v);
            end
        end
        // Partial row, then reset while its first window is in flight.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            valid_in = 1'b1; din1 = 24'($urandom); din2 = 24'($urandom); din3 = 24'($urandom);
        end
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (vo_a !== 1'b0 || dout_a !== 24'h0) begin
                n_fail++; $display("FAIL rst_mid: got valid %b dout %06h required 0/000000", vo_a, dout_a);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (vo_a !== 1'b0) begin n_fail++; $display("FAIL rst_after: got valid %b required 0", vo_a); end
        fill_random();
        run_frame(30);
        n_checks++;
        if (q_a.size() !== W*H) begin
            n_fail++; $display("FAIL post_rst_count: got %0d required %0d", q_a.size(), W*H);
        end
        foreach (q_a[i]) if (i < W*H) begin
            exp_v = model_px(i / W, i % W, mode, se_sel, BORDER_PASS);
            n_checks++;
            if (q_a[i] !== exp_v) begin
                n_fail++; $display("FAIL post_rst_px[%0d]: got %06h required %06h", i, q_a[i], exp_v);
            end
        end
    endtask

    task automatic test_border_const();
        fill_frame(24'h555555);
        mode = MODE_ERODE; se_sel = SE_SQUARE;
        run_frame(0);
        n_checks++;
        if (q_b.size() !== W*H) begin
            n_fail++; $display("FAIL bconst_count: got %0d required %0d", q_b.size(), W*H);
        end
        foreach (q_b[i]) if (i < W*H) begin
            exp_v = (i == 5 || i == 6 || i == 9 || i == 10) ? 24'h555555 : 24'h000000;
            n_checks++;
            if (q_b[i] !== exp_v) begin
                n_fail++; $display("FAIL bconst_px[%0d]: got %06h required %06h", i, q_b[i], exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            mode = 1'($urandom); se_sel = 1'($urandom);
            run_frame((f % 2) * 25);
            n_checks++;
            if (q_a.size() !== W*H || q_b.size() !== W*H) begin
                n_fail++; $display("FAIL b2b_count[%0d]: got %0d/%0d required %0d", f, q_a.size(), q_b.size(), W*H);
            end
            for (int i = 0; i < W*H && i < q_a.size() && i < q_b.size(); i++) begin
                exp_v = model_px(i / W, i % W, mode, se_sel, BORDER_PASS);
                n_checks++;
                if (q_a[i] !== exp_v) begin
                    n_fail++; $display("FAIL b2b_a[%0d][%0d]: got %06h required %06h", f, i, q_a[i], exp_v);
                end
                exp_v = model_px(i / W, i % W, mode, se_sel, BORDER_CONST);
                n_checks++;
                if (q_b[i] !== exp_v) begin
                    n_fail++; $display("FAIL b2b_b[%0d][%0d]: got %06h required %06h", f, i, q_b[i], exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat_erode_cross();
        test_dilate_square();
        test_erode_corner();
        test_channel_isolation();
        test_gaps_and_reset();
        test_border_const();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
